gcd_unit: RTL and testbench
===========================

Name: gcd_unit

Overview:
- Iterative subtract-based greatest-common-divisor engine.
- Two 16-bit operands arrive serially on one input bus: A first, then B on the following cycle.
- Repeated subtraction of the smaller from the larger runs until the operands are equal, then the result is presented and done is raised.
- Composed of a control FSM plus a datapath (operand registers, subtractor, comparator, muxes).

Parameters:
- WIDTH, 16, operand/result bit width

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  level request; sampled in IDLE to begin an operand-load sequence
- data_in  input  WIDTH  operand bus; A sampled in LOAD_A, B sampled in LOAD_B
- done  output  1  registered; high while in DONE state
- busy  output  1  registered; high in LOAD_A, LOAD_B, CALC
- gcd_out  output  WIDTH  registered result, valid while done=1
- a_out  output  WIDTH  current A register (observability)
- b_out  output  WIDTH  current B register (observability)

Behaviour:
- One clock domain; reset synchronous and active-high.
- Reset values: state=IDLE; A=B=gcd_out=0; done=0; busy=0.
- Reset has priority over all other activity, including mid-computation; the operation is abandoned.
- IDLE:
  - start=1 -> LOAD_A.
  - Otherwise stay.
- LOAD_A:
  - A <= data_in.
  - -> LOAD_B unconditionally.
- LOAD_B:
  - B <= data_in.
  - -> CALC unconditionally.
- CALC (one step per cycle, comparator on current A/B):
  - A==0 or B==0 or A==B -> gcd_out <= (A==0 ? B : A); -> DONE.
  - A>B -> A <= A-B; stay.
  - A<B -> B <= B-A; stay.
- Subtraction is unsigned WIDTH-bit. Underflow cannot occur because only the larger operand is reduced.
- Zero handling:
  - gcd(x,0) = gcd(0,x) = x.
  - gcd(0,0) = 0.
  - No endless loop on zero operands.
- DONE:
  - done=1, gcd_out held.
  - start=0 -> IDLE.
  - start=1 -> stay in DONE. start is level-sensitive; deassert it to re-arm.
- Output timing:
  - done/busy reflect the state registered at the same edge.
  - A, B and gcd_out are held until overwritten by a new LOAD_A/LOAD_B/CALC completion.
- start is ignored outside IDLE and DONE.
- Latency: from the edge loading B, done rises after (number of subtraction steps + 1) edges.

Decomposition:
- Shared package gcd_pkg:
  - State enum: IDLE, LOAD_A, LOAD_B, CALC, DONE.
  - WIDTH default constant.
- One natural sub-module, gcd_datapath:
  - A/B registers with load enables and subtract select.
  - Comparator providing lt/gt/eq and zero flags.
  - Result register.
- FSM lives in gcd_unit and drives load/select controls.

Test Plan:
- Basic operation:
  - Stimulus: reset, then start=1 held; data_in=169 on the first LOAD_A edge, 39 on the LOAD_B edge.
  - Required A/B sequence: (169,39), (130,39), (91,39), (52,39), (13,39), (13,26), (13,13).
  - Result: done=1 exactly 7 edges after the B load; gcd_out=13.
- Swapped operands:
  - Stimulus: A=39, B=169.
  - Required: B is reduced instead; gcd_out=13; same step count.
- Equal operands and multiple-step case:
  - A=25, B=25 -> done 1 edge after the B load; gcd_out=25.
  - A=48, B=18 -> gcd_out=6.
- Zero operands:
  - A=0, B=7 -> gcd_out=7, done 1 edge after the B load.
  - A=0, B=0 -> gcd_out=0.
- Reset mid-CALC:
  - Stimulus: assert reset during CALC.
  - Required after next edge: state IDLE, done=0, busy=0, A=B=gcd_out=0.
  - Required after reset release with start=1: a new load sequence starts normally.
- Re-arm:
  - Stimulus: in DONE with start held 1.
  - Required: stays in DONE.
  - Stimulus: drop start for one cycle, then raise it.
  - Required: returns to IDLE, then a new computation (A=65535, B=1) yields gcd_out=1.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtract-based GCD engine.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        DONE
    } gcd_state_t;

    // Datapath controls issued by the FSM each cycle.
    typedef struct packed {
        logic load_a;
        logic load_b;
        logic sub_a;
        logic sub_b;
        logic load_res;
    } gcd_ctrl_t;

    // Comparator/zero flags on the current A/B registers.
    typedef struct packed {
        logic a_gt_b;
        logic a_lt_b;
        logic a_eq_b;
        logic a_zero;
        logic b_zero;
    } gcd_flags_t;

endpackage

// File: rtl/gcd_if.sv
// Operand/result bus of the GCD engine; master drives requests, slave is the engine.
interface gcd_if #(
    parameter int WIDTH = gcd_pkg::GCD_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] gcd_out;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;

    modport master (
        output start, data_in,
        input  done, busy, gcd_out, a_out, b_out
    );

    modport slave (
        input  start, data_in,
        output done, busy, gcd_out, a_out, b_out
    );
endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, subtractor, comparator and result register for the GCD engine.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  gcd_ctrl_t        ctrl,
    output gcd_flags_t       flags,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] gcd_out
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;

    always_comb begin
        flags        = '0;
        flags.a_gt_b = (a_q > b_q);
        flags.a_lt_b = (a_q < b_q);
        flags.a_eq_b = (a_q == b_q);
        flags.a_zero = (a_q == '0);
        flags.b_zero = (b_q == '0);
    end

    // Only the larger operand is ever reduced, so the difference never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q <= '0;
        end else if (ctrl.load_a) begin
            a_q <= data_in;
        end else if (ctrl.sub_a) begin
            a_q <= a_q - b_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            b_q <= '0;
        end else if (ctrl.load_b) begin
            b_q <= data_in;
        end else if (ctrl.sub_b) begin
            b_q <= b_q - a_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            res_q <= '0;
        end else if (ctrl.load_res) begin
            res_q <= flags.a_zero ? b_q : a_q;
        end
    end

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign gcd_out = res_q;

endmodule

// File: rtl/gcd_unit.sv
// Subtract-based GCD engine: control FSM driving the gcd_datapath.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic  clock,
    input  logic  reset,
    gcd_if.slave  bus
);

    gcd_state_t state_q;
    gcd_state_t state_d;
    gcd_ctrl_t  ctrl;
    gcd_flags_t flags;
    logic       done_q;
    logic       busy_q;

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock   (clock),
        .reset   (reset),
        .data_in (bus.data_in),
        .ctrl    (ctrl),
        .flags   (flags),
        .a_out   (bus.a_out),
        .b_out   (bus.b_out),
        .gcd_out (bus.gcd_out)
    );

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD_A;
            end
            LOAD_A: begin
                ctrl.load_a = 1'b1;
                state_d     = LOAD_B;
            end
            LOAD_B: begin
                ctrl.load_b = 1'b1;
                state_d     = CALC;
            end
            CALC: begin
                // Zero operands terminate immediately so gcd(x,0) cannot loop.
                if (flags.a_zero || flags.b_zero || flags.a_eq_b) begin
                    ctrl.load_res = 1'b1;
                    state_d       = DONE;
                end else if (flags.a_gt_b) begin
                    ctrl.sub_a = 1'b1;
                end else if (flags.a_lt_b) begin
                    ctrl.sub_b = 1'b1;
                end
            end
            DONE: begin
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // done/busy are registered from the next state so they track state_q exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == CALC);
        end
    end

    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit against a Euclid-based reference model.
module tb_gcd_unit;

    localparam int W = 16;
    localparam int BOUND = 70000;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    gcd_if #(.WIDTH(W)) bus ();

    gcd_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference gcd by Euclid's remainder algorithm.
    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Edges from B load to done: subtraction count is the sum of Euclid quotients minus one.
    function automatic int ref_latency(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        int          q = 0;
        if (a == 0 || b == 0) return 1;
        if (x < y) begin t = x; x = y; y = t; end
        while (y != 0) begin
            q += int'(x / y);
            t = x % y;
            x = y;
            y = t;
        end
        return q;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From IDLE: request, then present A and B on consecutive load edges.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start   = 1'b1;
        tick();
        bus.data_in = a;
        tick();
        bus.data_in = b;
        tick();
    endtask

    task automatic wait_done(output int lat, output bit timeout);
        timeout = 1'b1;
        lat     = 0;
        for (int i = 1; i <= BOUND; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat     = i;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic finish_op();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int          lat;
        bit          to;
        int unsigned eg;
        int          el;
        eg = ref_gcd(a, b);
        el = ref_latency(a, b);
        start_op(a, b);
        wait_done(lat, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL %s timeout: done never rose (a=%0d b=%0d)", name, a, b);
        end else begin
            if (bus.gcd_out !== W'(eg)) begin
                bad++;
                $display("FAIL %s gcd: got %0d expected %0d (a=%0d b=%0d)", name, bus.gcd_out, eg, a, b);
            end
            total++;
            if (lat != el) begin
                bad++;
                $display("FAIL %s latency: got %0d expected %0d (a=%0d b=%0d)", name, lat, el, a, b);
            end
        end
        finish_op();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle: got done=%b busy=%b expected 0/0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.a_out !== '0 ||
            bus.b_out !== '0 || bus.gcd_out !== '0) begin
            bad++;
            $display("FAIL reset_state: got done=%b busy=%b a=%0d b=%0d gcd=%0d expected all 0",
                     bus.done, bus.busy, bus.a_out, bus.b_out, bus.gcd_out);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_a [7];
        logic [W-1:0] exp_b [7];
        exp_a = '{169, 130, 91, 52, 13, 13, 13};
        exp_b = '{39, 39, 39, 39, 39, 26, 13};
        start_op(16'd169, 16'd39);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (bus.a_out !== exp_a[i] || bus.b_out !== exp_b[i] || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_step%0d: got a=%0d b=%0d done=%b busy=%b expected a=%0d b=%0d done=0 busy=1",
                         i, bus.a_out, bus.b_out, bus.done, bus.busy, exp_a[i], exp_b[i]);
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.gcd_out !== 16'd13) begin
            bad++;
            $display("FAIL basic_done: got done=%b busy=%b gcd=%0d expected done=1 busy=0 gcd=13",
                     bus.done, bus.busy, bus.gcd_out);
        end
        finish_op();
    endtask

    task automatic test_swapped();
        start_op(16'd39, 16'd169);
        tick();
        total++;
        if (bus.a_out !== 16'd39 || bus.b_out !== 16'd130) begin
            bad++;
            $display("FAIL swapped_step: got a=%0d b=%0d expected a=39 b=130", bus.a_out, bus.b_out);
        end
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        total++;
        if (bus.done !== 1'b1 || bus.gcd_out !== 16'd13) begin
            bad++;
            $display("FAIL swapped_done: got done=%b gcd=%0d expected done=1 gcd=13", bus.done, bus.gcd_out);
        end
        tick();
    endtask

    task automatic test_directed();
        run_and_check("equal",   16'd25, 16'd25);
        run_and_check("multi",   16'd48, 16'd18);
        run_and_check("zero_a",  16'd0,  16'd7);
        run_and_check("zero_b",  16'd9,  16'd0);
        run_and_check("zero_ab", 16'd0,  16'd0);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            run_and_check("random", a, b);
        end
    endtask

    task automatic test_reset_mid_calc();
        start_op(16'd200, 16'd3);
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL midcalc_busy: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done);
        end
        reset = 1'b1;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.a_out !== '0 ||
            bus.b_out !== '0 || bus.gcd_out !== '0) begin
            bad++;
            $display("FAIL midcalc_reset: got done=%b busy=%b a=%0d b=%0d gcd=%0d expected all 0",
                     bus.done, bus.busy, bus.a_out, bus.b_out, bus.gcd_out);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        run_and_check("after_reset", 16'd48, 16'd18);
    endtask

    task automatic test_rearm();
        int lat;
        bit to;
        start_op(16'd21, 16'd14);
        wait_done(lat, to);
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (to || bus.done !== 1'b1 || bus.gcd_out !== 16'd7) begin
            bad++;
            $display("FAIL rearm_hold: got done=%b gcd=%0d timeout=%b expected done=1 gcd=7", bus.done, bus.gcd_out, to);
        end
        finish_op();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.gcd_out !== 16'd7) begin
            bad++;
            $display("FAIL rearm_idle: got done=%b busy=%b gcd=%0d expected 0/0 gcd held 7",
                     bus.done, bus.busy, bus.gcd_out);
        end
        run_and_check("rearm_big", 16'd65535, 16'd1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        test_basic();
        test_swapped();
        test_directed();
        test_random();
        test_reset_mid_calc();
        test_rearm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
